// File: rtl/bcd2bin.sv
// Pipelined signed-BCD to two's-complement converter, fixed 4-cycle latency, no backpressure.
// Optional feature: define BCD2BIN_SAT_EN to saturate out-of-range magnitudes to +/-1023.
module bcd2bin (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] bcd,
  input  logic        bcd_vld,
  output logic [10:0] bin,
  output logic        bin_vld,
  output logic        bin_err
);

  localparam int unsigned DigW  = 4;
  localparam int unsigned HiW   = 11;
  localparam int unsigned LoW   = 7;
  localparam int unsigned BinW  = 11;
  localparam int unsigned StgN  = 4;
  localparam logic [BinW-1:0] MagMax = BinW'(1023);

  logic [StgN-1:0] vld_q, vld_d;

  // S1: capture sign/digits and flag non-decimal digits or nonzero pad
  logic            s1_sign_q, s1_th_q, s1_err_q, s1_err_d;
  logic [DigW-1:0] s1_hu_q, s1_te_q, s1_on_q;

  // S2: partial products
  logic            s2_sign_q, s2_err_q;
  logic [HiW-1:0]  s2_phi_q, s2_phi_d;
  logic [LoW-1:0]  s2_plo_q, s2_plo_d;

  // S3: magnitude sum, then range check
  logic            s3_sign_q, s3_err_q;
  logic [HiW-1:0]  s3_mag_q, s3_mag_d;
  logic            s4_sign_q, s4_err_q, s4_ovf_q, s4_ovf_d;
  logic [HiW-1:0]  s4_mag_q;

  logic [BinW-1:0] bin_d;
  logic            bin_err_d;

  always_comb begin
    vld_d    = {vld_q[StgN-2:0], bcd_vld};
    s1_err_d = (bcd[11:8] > DigW'(9)) || (bcd[7:4] > DigW'(9)) ||
               (bcd[3:0] > DigW'(9))  || (bcd[15:13] != 3'b000);
  end

  // Shift-add only: 100x = 64x+32x+4x, 10x = 8x+2x
  always_comb begin
    logic [HiW-1:0] hu_w;
    logic [LoW-1:0] te_w;
    hu_w     = HiW'(s1_hu_q);
    te_w     = LoW'(s1_te_q);
    s2_phi_d = (s1_th_q ? HiW'(1000) : HiW'(0)) + (hu_w << 6) + (hu_w << 5) + (hu_w << 2);
    s2_plo_d = (te_w << 3) + (te_w << 1) + LoW'(s1_on_q);
  end

  always_comb begin
    s3_mag_d = s2_phi_q + HiW'(s2_plo_q);
    s4_ovf_d = s3_mag_q > MagMax;
  end

  // Output select: digit errors take precedence over range overflow
  always_comb begin
    bin_d     = '0;
    bin_err_d = 1'b0;
    if (s4_err_q) begin
      bin_d     = '0;
      bin_err_d = 1'b1;
    end else if (s4_ovf_q) begin
      bin_err_d = 1'b1;
`ifdef BCD2BIN_SAT_EN
      bin_d     = s4_sign_q ? BinW'(11'h401) : BinW'(11'h3FF);
`else
      bin_d     = '0;
`endif
    end else if (s4_sign_q) begin
      bin_d = (~{1'b0, s4_mag_q[9:0]}) + BinW'(1);
    end else begin
      bin_d = {1'b0, s4_mag_q[9:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      s1_sign_q <= 1'b0;
      s1_th_q   <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_hu_q   <= '0;
      s1_te_q   <= '0;
      s1_on_q   <= '0;
      s2_sign_q <= 1'b0;
      s2_err_q  <= 1'b0;
      s2_phi_q  <= '0;
      s2_plo_q  <= '0;
      s3_sign_q <= 1'b0;
      s3_err_q  <= 1'b0;
      s3_mag_q  <= '0;
      s4_sign_q <= 1'b0;
      s4_err_q  <= 1'b0;
      s4_ovf_q  <= 1'b0;
      s4_mag_q  <= '0;
      bin       <= '0;
      bin_err   <= 1'b0;
      bin_vld   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      bin_vld <= vld_q[3];
      if (bcd_vld) begin
        s1_sign_q <= bcd[16];
        s1_th_q   <= bcd[12];
        s1_hu_q   <= bcd[11:8];
        s1_te_q   <= bcd[7:4];
        s1_on_q   <= bcd[3:0];
        s1_err_q  <= s1_err_d;
      end
      if (vld_q[0]) begin
        s2_sign_q <= s1_sign_q;
        s2_err_q  <= s1_err_q;
        s2_phi_q  <= s2_phi_d;
        s2_plo_q  <= s2_plo_d;
      end
      if (vld_q[1]) begin
        s3_sign_q <= s2_sign_q;
        s3_err_q  <= s2_err_q;
        s3_mag_q  <= s3_mag_d;
      end
      if (vld_q[2]) begin
        s4_sign_q <= s3_sign_q;
        s4_err_q  <= s3_err_q;
        s4_ovf_q  <= s4_ovf_d;
        s4_mag_q  <= s3_mag_q;
      end
      if (vld_q[3]) begin
        bin     <= bin_d;
        bin_err <= bin_err_d;
      end
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Directed self-checking bench for bcd2bin; expected values hand-computed from the BCD format.
module tb_bcd2bin;

  logic        clk;
  logic        rst;
  logic [16:0] bcd;
  logic        bcd_vld;
  logic [10:0] bin;
  logic        bin_vld;
  logic        bin_err;

  int checks   = 0;
  int failures = 0;

  bcd2bin dut (
    .clk     (clk),
    .rst     (rst),
    .bcd     (bcd),
    .bcd_vld (bcd_vld),
    .bin     (bin),
    .bin_vld (bin_vld),
    .bin_err (bin_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Single word in, verify exact latency, pulse width and hold of result.
  task automatic conv(input string tag, input logic [16:0] word,
                      input logic [10:0] exp_bin, input logic exp_err);
    bcd = word; bcd_vld = 1'b1;
    @(posedge clk); #1;
    bcd_vld = 1'b0; bcd = '0;
    repeat (3) @(posedge clk);
    #1 chk({tag, "_early_vld"}, 32'(bin_vld), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 32'(bin_vld), 32'd1);
    chk({tag, "_bin"}, 32'(bin), 32'(exp_bin));
    chk({tag, "_err"}, 32'(bin_err), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, "_vld_off"}, 32'(bin_vld), 32'd0);
    chk({tag, "_hold"}, 32'(bin), 32'(exp_bin));
  endtask

  logic [10:0] ovf_pos, ovf_neg;

  initial begin
`ifdef BCD2BIN_SAT_EN
    ovf_pos = 11'h3FF; ovf_neg = 11'h401;
`else
    ovf_pos = 11'h000; ovf_neg = 11'h000;
`endif
    rst = 1'b1; bcd = '0; bcd_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_vld", 32'(bin_vld), 32'd0);
    chk("rst_err", 32'(bin_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    conv("p999",   17'h00999, 11'h3E7, 1'b0);
    conv("n1023",  17'h11023, 11'h401, 1'b0);
    conv("p1023",  17'h01023, 11'h3FF, 1'b0);
    conv("negz",   17'h10000, 11'h000, 1'b0);
    conv("tensA",  17'h000A5, 11'h000, 1'b1);
    conv("pad",    17'h02005, 11'h000, 1'b1);
    conv("povf",   17'h01999, ovf_pos, 1'b1);
    conv("novf",   17'h11999, ovf_neg, 1'b1);
    conv("onesF",  17'h1000F, 11'h000, 1'b1);
    conv("n1024",  17'h11024, ovf_neg, 1'b1);

    // Back-to-back words produce back-to-back results
    bcd = 17'h00001; bcd_vld = 1'b1;
    @(posedge clk); #1 bcd = 17'h10002;
    @(posedge clk); #1 bcd = 17'h00123;
    @(posedge clk); #1 bcd_vld = 1'b0; bcd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b0_vld", 32'(bin_vld), 32'd1);
    chk("b2b0_bin", 32'(bin), 32'h001);
    @(posedge clk); #1;
    chk("b2b1_vld", 32'(bin_vld), 32'd1);
    chk("b2b1_bin", 32'(bin), 32'h7FE);
    @(posedge clk); #1;
    chk("b2b2_vld", 32'(bin_vld), 32'd1);
    chk("b2b2_bin", 32'(bin), 32'h07B);
    chk("b2b2_err", 32'(bin_err), 32'd0);
    @(posedge clk); #1;
    chk("b2b_end_vld", 32'(bin_vld), 32'd0);

    // Reset with three words in flight discards them
    bcd = 17'h00111; bcd_vld = 1'b1;
    @(posedge clk); #1 bcd = 17'h00222;
    @(posedge clk); #1 bcd = 17'h00333;
    @(posedge clk); #1 bcd_vld = 1'b0; bcd = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_vld", 32'(bin_vld), 32'd0);
      @(posedge clk); #1;
    end
    chk("flush_bin", 32'(bin), 32'd0);
    chk("flush_err", 32'(bin_err), 32'd0);

    // Reset and valid in the same cycle: word dropped
    bcd = 17'h00555; bcd_vld = 1'b1; rst = 1'b1;
    @(posedge clk); #1 bcd_vld = 1'b0; rst = 1'b0; bcd = '0;
    for (int i = 0; i < 6; i++) begin
      chk("rstwin_vld", 32'(bin_vld), 32'd0);
      @(posedge clk); #1;
    end

    conv("post", 17'h00999, 11'h3E7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
